word_byte_serializer: RTL and testbench
=======================================

# word_byte_serializer

Serializes a multi-byte word (default 16 bits) onto an 8-bit byte stream, one byte per handshake. It is the read-side counterpart of the byte-select constant loader: the loader assembles a word from bytes, and this block disassembles a word back into bytes for the 8-bit data path. A valid/ready handshake is used on both the word input and the byte output. Back-to-back words are supported with no bubble cycle.

## Interface

Parameters:
- WORD_BYTES, 2: number of bytes per word (≥2); word width = 8*WORD_BYTES.
- MSB_FIRST, 0: 0 = byte 0 (bits [7:0]) sent first; 1 = most-significant byte sent first.

Ports. Clock and reset are **already decided**: reset is reset, asynchronous, active-high; clock is clk.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- word_in  input  8*WORD_BYTES  word to serialize; sampled on word accept.
- word_valid  input  1  word_in valid.
- word_ready  output  1  block can accept a word this cycle.
- abort  input  1  synchronous; discards the word in flight.
- byte_out  output  8  current byte.
- byte_valid  output  1  byte_out valid.
- byte_ready  input  1  downstream accepts byte_out this cycle.
- byte_index  output  $clog2(WORD_BYTES)  position of byte_out within the word (0 = bits [7:0]).
- byte_last  output  1  byte_out is the final byte of the word.
- busy  output  1  word in flight (state SEND).

## Operation

- Two states:
  - IDLE: byte_valid = 0.
  - SEND: byte_valid = 1; a byte is presented.
- Word accept: word_valid && word_ready at a rising edge.
- Byte accept: byte_valid && byte_ready at a rising edge.
- word_ready is combinational:
  - word_ready = !abort && (state == IDLE || (byte_valid && byte_ready && byte_last)).
  - This creates a combinational path from byte_ready and abort to word_ready. That path is permitted.
- On word accept:
  - word_in is captured into the shift register.
  - Byte counter is set to 0.
  - State becomes SEND.
- On byte accept, non-last byte: counter increments and the next byte is presented.
- On byte accept, last byte:
  - If a word is accepted in the same cycle: reload and stay in SEND.
  - Otherwise: go to IDLE.
- byte_out ordering:
  - MSB_FIRST = 0: byte_out = word[8*cnt +: 8]; byte_index = cnt.
  - MSB_FIRST = 1: byte_index = WORD_BYTES-1-cnt.
  - byte_out is always word[8*byte_index +: 8].
- byte_last = byte_valid && (cnt == WORD_BYTES-1).
- Stability under backpressure: while byte_valid && !byte_ready, byte_out, byte_index and byte_last hold stable. The captured word is never modified mid-word.
- abort:
  - At the next edge: state = IDLE, cnt = 0, byte_valid = 0.
  - The remaining bytes are dropped.
  - abort has priority over a byte accept and a word accept in the same cycle. word_ready is low, so no word is taken.
  - abort while in IDLE has no effect.
- Reset:
  - Outputs: byte_valid = 0, byte_out = 0x00, byte_index = 0, byte_last = 0, busy = 0, word_ready = 1 (if abort = 0).
  - Captured word cleared to 0.
  - Reset mid-word discards the word; no byte is emitted after reset deasserts until a new word accept.
- busy = (state == SEND).

## Timing

- Latency: word accept at edge N gives the first byte valid in cycle N+1 (registered).
- Throughput: one byte per cycle while byte_ready = 1.
- With continuous word_valid and byte_ready, a word of WORD_BYTES bytes takes exactly WORD_BYTES cycles, with zero idle cycles between words.
- byte_valid never deasserts without a byte accept, abort or reset.
- All outputs are registered except word_ready.

## Test plan

- **Reset:**
  - Stimulus: assert reset mid-SEND (second byte pending), then release.
  - Required: byte_valid = 0, byte_out = 0x00, busy = 0, word_ready = 1; no byte appears until a new word_valid.
- **Single word, LSB first:**
  - Stimulus: word_in = 0xA5C3, byte_ready = 1.
  - Required: cycle N+1 byte_out = 0xC3, index 0, last 0; cycle N+2 byte_out = 0xA5, index 1, last 1; cycle N+3 byte_valid = 0.
- **Backpressure:**
  - Stimulus: word 0x1234, byte_ready low for 3 cycles, then high.
  - Required: 0x34 held stable for 4 cycles, then 0x12 for 1 cycle; word_ready = 0 throughout until last accept.
- **Back-to-back words:**
  - Stimulus: 0x1111, 0x2222, 0x3333 with word_valid and byte_ready always high.
  - Required: byte stream 11 11 22 22 33 33 on consecutive cycles; word_ready pulses on each last byte.
- **Abort:**
  - Stimulus: abort asserted with word 0xBEEF waiting on byte 0xEF; word_valid high in the same cycle.
  - Required: next cycle byte_valid = 0, busy = 0; 0xBE never emitted; no word accepted in the abort cycle.
- **MSB_FIRST = 1, WORD_BYTES = 4:**
  - Stimulus: word 0x01020304.
  - Required: bytes 01, 02, 03, 04 with byte_index 3, 2, 1, 0; byte_last asserted on 04.

Source files
------------

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: splits a captured word into a byte stream,
// one byte per valid/ready handshake, with no bubble between words.
module word_byte_serializer #(
  parameter int WORD_BYTES = 2,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [8*WORD_BYTES-1:0]       word_in,
  input  logic                          word_valid,
  output logic                          word_ready,
  input  logic                          abort,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [$clog2(WORD_BYTES)-1:0] byte_index,
  output logic                          byte_last,
  output logic                          busy
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_BYTES - 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    word_q, word_d;
  logic [7:0]      byte_out_q, byte_out_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            last_q, last_d;

  logic            sending;
  logic            at_last;
  logic            byte_acc;
  logic            word_acc;

  assign sending  = (state_q == S_SEND);
  assign at_last  = (cnt_q == CNT_LAST);
  assign byte_acc = sending && byte_ready;

  // Ready may open on the final byte so the next word loads bubble-free.
  assign word_ready = !abort && (!sending || (byte_acc && at_last));
  assign word_acc   = word_valid && word_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (word_acc) begin
      state_d = S_SEND;
      cnt_d   = '0;
      word_d  = word_in;
    end else if (byte_acc) begin
      if (at_last) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Output byte is computed from next-state so it is registered.
  always_comb begin
    if (MSB_FIRST) begin
      idx_d = CNT_LAST - cnt_d;
    end else begin
      idx_d = cnt_d;
    end
    byte_out_d = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (idx_d == CW'(i)) begin
        byte_out_d = word_d[8*i +: 8];
      end
    end
    last_d = (state_d == S_SEND) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      byte_out_q <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      byte_out_q <= byte_out_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_index = idx_q;
  assign byte_last  = last_q;
  assign byte_valid = sending;
  assign busy       = sending;

endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench for word_byte_serializer: a 2-byte LSB-first
// instance and a 4-byte MSB-first instance on a shared clock.
module tb_word_byte_serializer;

  logic clk;
  logic reset;

  logic [15:0] a_word_in;
  logic        a_word_valid, a_word_ready, a_abort;
  logic [7:0]  a_byte_out;
  logic        a_byte_valid, a_byte_ready;
  logic [0:0]  a_byte_index;
  logic        a_byte_last, a_busy;

  logic [31:0] b_word_in;
  logic        b_word_valid, b_word_ready, b_abort;
  logic [7:0]  b_byte_out;
  logic        b_byte_valid, b_byte_ready;
  logic [1:0]  b_byte_index;
  logic        b_byte_last, b_busy;

  int compared;
  int mism;

  word_byte_serializer #(.WORD_BYTES(2), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .reset(reset),
    .word_in(a_word_in), .word_valid(a_word_valid),
    .word_ready(a_word_ready), .abort(a_abort),
    .byte_out(a_byte_out), .byte_valid(a_byte_valid),
    .byte_ready(a_byte_ready), .byte_index(a_byte_index),
    .byte_last(a_byte_last), .busy(a_busy)
  );

  word_byte_serializer #(.WORD_BYTES(4), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .word_in(b_word_in), .word_valid(b_word_valid),
    .word_ready(b_word_ready), .abort(b_abort),
    .byte_out(b_byte_out), .byte_valid(b_byte_valid),
    .byte_ready(b_byte_ready), .byte_index(b_byte_index),
    .byte_last(b_byte_last), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v,
                       input logic [7:0] b, input logic i,
                       input logic l);
    chk({tag, ".valid"}, 32'(a_byte_valid), 32'(v));
    chk({tag, ".byte"}, 32'(a_byte_out), 32'(b));
    chk({tag, ".index"}, 32'(a_byte_index), 32'(i));
    chk({tag, ".last"}, 32'(a_byte_last), 32'(l));
  endtask

  logic [15:0] words [3];
  logic [15:0] cur;

  initial begin
    compared = 0;
    mism     = 0;
    reset    = 1'b1;
    a_word_in = '0; a_word_valid = 0; a_abort = 0; a_byte_ready = 0;
    b_word_in = '0; b_word_valid = 0; b_abort = 0; b_byte_ready = 0;
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;

    tick;
    tick;
    chk_a("rst_a", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_a.busy", 32'(a_busy), 32'd0);
    chk("rst_a.wready", 32'(a_word_ready), 32'd1);
    chk("rst_b.valid", 32'(b_byte_valid), 32'd0);
    chk("rst_b.byte", 32'(b_byte_out), 32'h00);
    chk("rst_b.index", 32'(b_byte_index), 32'd0);
    chk("rst_b.wready", 32'(b_word_ready), 32'd1);
    reset = 1'b0;

    // single word, LSB first
    tick;
    a_word_in = 16'hA5C3; a_word_valid = 1; a_byte_ready = 1;
    #1;
    chk("single.wready_idle", 32'(a_word_ready), 32'd1);
    tick;
    a_word_valid = 0;
    #1;
    chk_a("single.n1", 1'b1, 8'hC3, 1'b0, 1'b0);
    chk("single.n1.busy", 32'(a_busy), 32'd1);
    tick;
    chk_a("single.n2", 1'b1, 8'hA5, 1'b1, 1'b1);
    chk("single.n2.wready", 32'(a_word_ready), 32'd1);
    tick;
    chk("single.n3.valid", 32'(a_byte_valid), 32'd0);
    chk("single.n3.busy", 32'(a_busy), 32'd0);

    // backpressure
    a_word_in = 16'h1234; a_word_valid = 1; a_byte_ready = 0;
    tick;
    a_word_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_a("bp.hold", 1'b1, 8'h34, 1'b0, 1'b0);
      chk("bp.hold.wready", 32'(a_word_ready), 32'd0);
      tick;
    end
    a_byte_ready = 1;
    #1;
    chk_a("bp.hold4", 1'b1, 8'h34, 1'b0, 1'b0);
    chk("bp.hold4.wready", 32'(a_word_ready), 32'd0);
    tick;
    chk_a("bp.b1", 1'b1, 8'h12, 1'b1, 1'b1);
    chk("bp.b1.wready", 32'(a_word_ready), 32'd1);
    tick;
    chk("bp.done.valid", 32'(a_byte_valid), 32'd0);

    // back-to-back words
    a_word_in = words[0]; a_word_valid = 1; a_byte_ready = 1;
    tick;
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 2; b++) begin
        if (b == 1) begin
          if (w < 2) a_word_in = words[w+1];
          else a_word_valid = 0;
        end
        #1;
        cur = words[w];
        chk_a("b2b", 1'b1, cur[8*b +: 8], b[0], b[0]);
        chk("b2b.wready", 32'(a_word_ready), 32'(b == 1));
        tick;
      end
    end
    chk("b2b.end.valid", 32'(a_byte_valid), 32'd0);

    // abort with a competing word
    a_word_in = 16'hBEEF; a_word_valid = 1; a_byte_ready = 0;
    tick;
    a_abort = 1; a_word_in = 16'hCAFE; a_byte_ready = 1;
    #1;
    chk("abort.wready", 32'(a_word_ready), 32'd0);
    chk_a("abort.pre", 1'b1, 8'hEF, 1'b0, 1'b0);
    tick;
    a_abort = 0; a_word_valid = 0;
    #1;
    chk("abort.post.valid", 32'(a_byte_valid), 32'd0);
    chk("abort.post.busy", 32'(a_busy), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("abort.quiet.valid", 32'(a_byte_valid), 32'd0);
    end

    // abort while idle is harmless
    a_abort = 1;
    #1;
    chk("abort_idle.wready", 32'(a_word_ready), 32'd0);
    tick;
    a_abort = 0;
    #1;
    chk("abort_idle.valid", 32'(a_byte_valid), 32'd0);
    chk("abort_idle.wready2", 32'(a_word_ready), 32'd1);

    // reset while the second byte is pending
    a_word_in = 16'h5AA5; a_word_valid = 1; a_byte_ready = 1;
    tick;
    a_word_valid = 0;
    tick;
    a_byte_ready = 0;
    #1;
    chk_a("rstmid.pend", 1'b1, 8'h5A, 1'b1, 1'b1);
    #2;
    reset = 1;
    #1;
    chk_a("rstmid.in", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rstmid.busy", 32'(a_busy), 32'd0);
    chk("rstmid.wready", 32'(a_word_ready), 32'd1);
    tick;
    reset = 0;
    a_byte_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rstmid.quiet.valid", 32'(a_byte_valid), 32'd0);
      chk("rstmid.quiet.byte", 32'(a_byte_out), 32'h00);
    end

    // 4-byte MSB-first instance
    b_word_in = 32'h01020304; b_word_valid = 1; b_byte_ready = 1;
    tick;
    b_word_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("msb.valid", 32'(b_byte_valid), 32'd1);
      chk("msb.byte", 32'(b_byte_out), 32'(i + 1));
      chk("msb.index", 32'(b_byte_index), 32'(3 - i));
      chk("msb.last", 32'(b_byte_last), 32'(i == 3));
      tick;
    end
    chk("msb.end.valid", 32'(b_byte_valid), 32'd0);
    chk("msb.end.busy", 32'(b_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
